// File: rtl/reg_file_param.sv
// Parametrised DEPTH x WIDTH register file with shared clear/load/dec/inc function code,
// per-register wrap/clamp event pulses, zero status and two combinational read ports.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module reg_file_param #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 8,
    parameter int               SEL_W     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SAT       = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load,
    input  logic [1:0]       funsel,
    input  logic [DEPTH-1:0] rsel,
    input  logic [SEL_W-1:0] o1sel,
    input  logic [SEL_W-1:0] o2sel,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [DEPTH-1:0] zero,
    output logic [DEPTH-1:0] evt
);

    localparam logic [1:0] FN_CLR = 2'b00;
    localparam logic [1:0] FN_LD  = 2'b01;
    localparam logic [1:0] FN_DEC = 2'b10;
    localparam logic [1:0] FN_INC = 2'b11;

    logic [WIDTH-1:0] regs   [DEPTH];
    logic [WIDTH-1:0] nxt    [DEPTH];
    logic [WIDTH-1:0] rd_val [DEPTH];
    logic [DEPTH-1:0] hit;

    // Next value of one register under the shared function code, with wrap or clamp.
    function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] cur,
                                                  input logic [1:0]       fs,
                                                  input logic [WIDTH-1:0] ld);
        logic [WIDTH-1:0] res;
        case (fs)
            FN_CLR:  res = '0;
            FN_LD:   res = ld;
            FN_DEC:  res = (SAT && cur == '0) ? cur : cur - WIDTH'(1);
            default: res = (SAT && (&cur))    ? cur : cur + WIDTH'(1);
        endcase
        return res;
    endfunction

    // An event is the boundary crossing itself, whether it wrapped or was clamped.
    function automatic logic boundary_hit(input logic [WIDTH-1:0] cur,
                                          input logic [1:0]       fs);
        return (fs == FN_INC && (&cur)) || (fs == FN_DEC && cur == '0);
    endfunction

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = next_val(regs[i], funsel, load);
            hit[i] = boundary_hit(regs[i], funsel);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
            evt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rsel[i]) regs[i] <= nxt[i];
            end
            evt <= rsel & hit;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rd_val[i] = regs[i];
`ifdef RF_BYPASS_EN
            if (rsel[i] && !rst) rd_val[i] = nxt[i];
`endif
        end
    end

    // Selects at or beyond DEPTH match no register and read back as zero.
    always_comb begin
        o1   = '0;
        o2   = '0;
        zero = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (o1sel == SEL_W'(i)) o1 = rd_val[i];
            if (o2sel == SEL_W'(i)) o2 = rd_val[i];
            zero[i] = (regs[i] == '0);
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: wrapping default build, saturating build and a
// DEPTH=6 build driven side by side; bypass expectations follow RF_BYPASS_EN.
module tb_reg_file_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] load;
    logic [1:0] funsel;
    logic [7:0] rsel;
    logic [5:0] rsel6;
    logic [2:0] o1sel, o2sel;

    logic [7:0] a_o1, a_o2, a_zero, a_evt;
    logic [7:0] b_o1, b_o2, b_zero, b_evt;
    logic [7:0] c_o1, c_o2;
    logic [5:0] c_zero, c_evt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_param #(.WIDTH(8), .DEPTH(8), .SEL_W(3), .RESET_VAL(8'h00), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .load(load), .funsel(funsel), .rsel(rsel),
        .o1sel(o1sel), .o2sel(o2sel), .o1(a_o1), .o2(a_o2), .zero(a_zero), .evt(a_evt));

    reg_file_param #(.WIDTH(8), .DEPTH(8), .SEL_W(3), .RESET_VAL(8'h00), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .load(load), .funsel(funsel), .rsel(rsel),
        .o1sel(o1sel), .o2sel(o2sel), .o1(b_o1), .o2(b_o2), .zero(b_zero), .evt(b_evt));

    reg_file_param #(.WIDTH(8), .DEPTH(6), .SEL_W(3), .RESET_VAL(8'h00), .SAT(1'b0)) u_d6 (
        .clk(clk), .rst(rst), .load(load), .funsel(funsel), .rsel(rsel6),
        .o1sel(o1sel), .o2sel(o2sel), .o1(c_o1), .o2(c_o2), .zero(c_zero), .evt(c_evt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; enables drop right after it so later reads see stored contents.
    task automatic tick();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        rsel  = '0;
        rsel6 = '0;
    endtask

    initial begin
        rst = 1'b1; load = '0; funsel = 2'b00; rsel = '0; rsel6 = '0;
        o1sel = 3'd0; o2sel = 3'd7;
        tick();
        chk("rst_o1",   32'(a_o1),   32'h00);
        chk("rst_o2",   32'(a_o2),   32'h00);
        chk("rst_zero", 32'(a_zero), 32'hFF);
        chk("rst_evt",  32'(a_evt),  32'h00);

        // Parallel load into registers 0 and 2
        o2sel = 3'd2; rsel = 8'b0000_0101; funsel = 2'b01; load = 8'hA5;
        tick();
        chk("pload_o1",   32'(a_o1),   32'hA5);
        chk("pload_o2",   32'(a_o2),   32'hA5);
        chk("pload_zero", 32'(a_zero), 32'hFA);

        // Reset wins over a simultaneous load
        rst = 1'b1; rsel = 8'hFF; funsel = 2'b01; load = 8'h77;
        tick();
        chk("rstovr_o1",   32'(a_o1),   32'h00);
        chk("rstovr_o2",   32'(a_o2),   32'h00);
        chk("rstovr_zero", 32'(a_zero), 32'hFF);

        // Wrap / clamp on register 3
        o1sel = 3'd3; rsel = 8'h08; funsel = 2'b01; load = 8'hFF;
        tick();
        chk("ld3_o1",  32'(a_o1),  32'hFF);
        chk("ld3_evt", 32'(a_evt), 32'h00);
        rsel = 8'h08; funsel = 2'b11;
        tick();
        chk("inc_wrap_o1",  32'(a_o1),  32'h00);
        chk("inc_wrap_evt", 32'(a_evt), 32'h08);
        chk("inc_sat_o1",   32'(b_o1),  32'hFF);
        chk("inc_sat_evt",  32'(b_evt), 32'h08);
        tick();
        chk("evt_one_cycle", 32'(a_evt), 32'h00);
        chk("hold_o1",       32'(a_o1),  32'h00);
        rsel = 8'h08; funsel = 2'b10;
        tick();
        chk("dec_wrap_o1",  32'(a_o1),  32'hFF);
        chk("dec_wrap_evt", 32'(a_evt), 32'h08);
        chk("dec_sat_o1",   32'(b_o1),  32'hFE);
        chk("dec_sat_evt",  32'(b_evt), 32'h00);
        tick();
        chk("dec_evt_clear", 32'(a_evt), 32'h00);

        // Saturation on register 1, back-to-back increments
        o1sel = 3'd1; rsel = 8'h02; funsel = 2'b01; load = 8'hFE;
        tick();
        rsel = 8'h02; funsel = 2'b11;
        tick();
        chk("sat_inc1_o1",  32'(b_o1),  32'hFF);
        chk("sat_inc1_evt", 32'(b_evt), 32'h00);
        rsel = 8'h02; funsel = 2'b11;
        tick();
        chk("sat_inc2_o1",  32'(b_o1),  32'hFF);
        chk("sat_inc2_evt", 32'(b_evt), 32'h02);
        chk("wrap_inc2_o1",  32'(a_o1),  32'h00);
        chk("wrap_inc2_evt", 32'(a_evt), 32'h02);
        rsel = 8'h02; funsel = 2'b00;
        tick();
        chk("clr_evt", 32'(b_evt), 32'h00);
        rsel = 8'h02; funsel = 2'b10;
        tick();
        chk("sat_dec0_o1",  32'(b_o1),  32'h00);
        chk("sat_dec0_evt", 32'(b_evt), 32'h02);
        chk("wrap_dec0_o1", 32'(a_o1),  32'hFF);

        // Out-of-range selects on the DEPTH=6 file
        rsel6 = 6'b10_0000; funsel = 2'b01; load = 8'h3C;
        tick();
        o1sel = 3'd6; o2sel = 3'd7;
        #1;
        chk("oor_o1",  32'(c_o1),   32'h00);
        chk("oor_o2",  32'(c_o2),   32'h00);
        chk("d6_zero", 32'(c_zero), 32'h1F);
        o1sel = 3'd5; o2sel = 3'd5;
        #1;
        chk("same_o1", 32'(c_o1), 32'h3C);
        chk("same_o2", 32'(c_o2), 32'h3C);

        // Bypass visibility on register 4
        o1sel = 3'd4; rsel = 8'h10; funsel = 2'b01; load = 8'h10;
        tick();
        rsel = 8'h10; funsel = 2'b11;
        #1;
`ifdef RF_BYPASS_EN
        chk("byp_pre_o1", 32'(a_o1), 32'h11);
`else
        chk("byp_pre_o1", 32'(a_o1), 32'h10);
`endif
        tick();
        chk("byp_post_o1", 32'(a_o1), 32'h11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the fixed 8-register, 8-bit general register file.
- Holds DEPTH registers of WIDTH bits. Each register has its own enable bit; all enabled registers receive one shared 2-bit function code (clear / load / decrement / increment).
- Two independent combinational read ports feed the ALU operand muxes.
- Adds what the 8x8 file lacks: synchronous reset, saturating or wrapping counters, per-register wrap/clamp event pulses, a zero-status vector, and optional write-to-read bypass.

Parameters:
- WIDTH, 8, bit width of each register and of load/o1/o2.
- DEPTH, 8, number of registers; legal range 2..16.
- SEL_W, 3, read-select width; must satisfy 2**SEL_W >= DEPTH.
- RESET_VAL, 0, value every register takes on reset (WIDTH bits).
- SAT, 0, 0 = inc/dec wrap modulo 2**WIDTH; 1 = inc/dec saturate at all-ones / zero.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- load  in  WIDTH  write data for funsel=01
- funsel  in  2  00 clear, 01 load, 10 decrement, 11 increment
- rsel  in  DEPTH  per-register enable; bit i enables register i; any number of bits may be set
- o1sel  in  SEL_W  read port 1 select
- o2sel  in  SEL_W  read port 2 select
- o1  out  WIDTH  read port 1 data
- o2  out  WIDTH  read port 2 data
- zero  out  DEPTH  bit i = 1 when register i == 0
- evt  out  DEPTH  bit i = 1-cycle pulse on a wrap (SAT=0) or clamp (SAT=1) event in register i

Behaviour:
- Reset:
  - On a rising clk edge with rst=1, every register takes RESET_VAL and evt clears to 0.
  - rst overrides rsel/funsel in that cycle, including mid-sequence.
  - After reset, o1/o2 show RESET_VAL and zero = all-ones iff RESET_VAL == 0.
- Write, per register i on a rising edge with rst=0 and rsel[i]=1:
  - 00: reg <= 0.
  - 01: reg <= load.
  - 10: decrement.
    - SAT=0: reg <= reg-1 modulo 2**WIDTH.
    - SAT=1: reg at 0 stays 0.
  - 11: increment.
    - SAT=0: reg <= reg+1 modulo 2**WIDTH.
    - SAT=1: reg at all-ones stays all-ones.
- Registers with rsel[i]=0 hold their value.
- Multiple enabled registers update in parallel from the same load/funsel. No priority, no interaction between registers.
- Event pulse evt[i], registered and valid the cycle after the triggering edge, lasts exactly one cycle:
  - Set when rsel[i]=1 and either: funsel=11 with reg == all-ones, or funsel=10 with reg == 0.
  - Applies in both SAT modes: it flags a wrap when SAT=0 and a clamp when SAT=1.
  - Otherwise evt[i] <= 0.
  - Back-to-back events give evt high on consecutive cycles.
- Read ports:
  - Purely combinational, zero latency: o1 = reg[o1sel], o2 = reg[o2sel].
  - Both ports may select the same register.
  - A select value >= DEPTH returns 0.
  - A write becomes visible on o1/o2 immediately after the clock edge (see the optional feature for same-cycle visibility).
- zero is combinational from current register contents.
- Arithmetic is unsigned WIDTH-bit. No carry-out port; evt replaces it.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Each read port forwards the pending write value in the same cycle, combinationally, when its selected register has rsel=1 and rst=0.
  - The forwarded value is the next-state value: 0, load, dec result or inc result, with SAT rules applied.
  - When rst=1, the read ports show the stored contents (no forwarding).
  - Adds one adder/mux path per read port.
- Undefined: reads always return stored contents; no forwarding logic is synthesised.

Test Plan:
- Reset, defaults (WIDTH=8, DEPTH=8, RESET_VAL=0): hold rst=1 one cycle, then o1sel=0, o2sel=7 -> o1=0x00, o2=0x00, zero=0xFF, evt=0x00.
- Parallel load: rsel=8'b0000_0101, funsel=01, load=0xA5 -> regs 0 and 2 = 0xA5, others 0, zero=0xFA; a simultaneous rst=1 in the same cycle leaves all regs 0.
- Wrap (SAT=0): load reg3=0xFF, then funsel=11, rsel[3]=1 -> reg3=0x00, evt[3]=1 for exactly the next cycle. Decrement at 0x00 -> 0xFF, evt[3] pulses.
- Saturate (SAT=1): reg1=0xFE, increment twice -> 0xFF then 0xFF; evt[1]=0 after the first increment, 1 after the second. Decrement at 0x00 stays 0x00 with an evt pulse.
- Out-of-range select (DEPTH=6, SEL_W=3): o1sel=6, o2sel=7 -> o1=0, o2=0. o1sel=o2sel=5 with reg5=0x3C -> both ports 0x3C.
- Bypass, RF_BYPASS_EN defined: reg4=0x10, o1sel=4, rsel[4]=1, funsel=11 -> o1=0x11 before the edge; without the macro o1=0x10 until after the edge.
